// File: rtl/wr_arbiter.sv
// Round-robin burst arbiter feeding the async FIFO write port from NUM_REQ producers.
// Optional per-requester transfer counters are enabled with `define WR_ARB_STATS_EN.
module wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                           wr_clk,
    input  logic                           wr_rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           wr_full,
    output logic                           wr_inc,
    output logic [DATA_SIZE-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]     gnt_id,
    output logic                           busy
`ifdef WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]          xfer_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam int BW   = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [ID_W-1:0]     last;
    logic [BW-1:0]       beat_cnt;
    logic                xfer;
    logic                release_gnt;
    logic                any_req;
    logic [ID_W-1:0]     pick_idle;
    logic [ID_W-1:0]     pick_rel;
    logic [DATA_SIZE-1:0] req_words [NUM_REQ];

    // Search from one past 'from' upward with wrap, so 'from' itself is tried last.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                                input logic [ID_W-1:0]    from);
        logic [ID_W-1:0] sel;
        logic [ID_W:0]   s;
        logic            found;
        sel   = from;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            s = {1'b0, from} + (ID_W+1)'(k);
            if (s >= (ID_W+1)'(NUM_REQ))
                s = s - (ID_W+1)'(NUM_REQ);
            if (!found && v[s[ID_W-1:0]]) begin
                sel   = s[ID_W-1:0];
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
        assign req_words[i] = req_data[i*DATA_SIZE +: DATA_SIZE];
    end

    assign any_req     = |req_valid;
    assign pick_idle   = rr_pick(req_valid, last);
    assign pick_rel    = rr_pick(req_valid, gnt_id);
    // A word offered while reset is asserted must not reach the FIFO.
    assign xfer        = (state == GRANT) && req_valid[gnt_id] && !wr_full && !wr_rst;
    assign release_gnt = (xfer && (beat_cnt == BW'(MAX_BURST - 1))) || !req_valid[gnt_id];
    assign wr_inc      = xfer;
    assign wr_data     = req_words[gnt_id];
    assign busy        = (state == GRANT);

    always_comb begin
        req_ready         = '0;
        req_ready[gnt_id] = xfer;
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state    <= IDLE;
            gnt_id   <= '0;
            last     <= ID_W'(NUM_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt_id   <= pick_idle;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_gnt) begin
                        last     <= gnt_id;
                        beat_cnt <= '0;
                        if (any_req) begin
                            gnt_id <= pick_rel;
                            state  <= GRANT;
                        end else begin
                            state  <= IDLE;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WR_ARB_STATS_EN
    logic [15:0] cnt [NUM_REQ];

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                if (req_ready[i] && (cnt[i] != 16'hFFFF))
                    cnt[i] <= cnt[i] + 16'd1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        assign xfer_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule
